mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch stage
// (instruction reads) and the memory stage (loads/stores). Data side has
// priority; a requester is never granted two cycles in a row, so the other
// side always gets a turn when both keep requesting.
// Build option: define ARB_STARVE_EN to add a fetch starvation counter that
// forces a fetch grant after STARVE_MAX consecutive lost cycles.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic [15:0] if_rdata,
  output logic        if_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic [15:0] d_rdata,
  output logic        d_rvalid,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // owner encoding used in the latched request and the return pipeline
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        we_reg, we_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;

  logic        if_elig, d_elig;
  logic        fetch_prio;
  logic        if_win, d_win;

  logic [MEM_LAT-1:0] ret_valid_reg;
  logic [MEM_LAT-1:0] ret_owner_reg;
  logic               ret_valid, ret_owner;
  logic [15:0]        if_rdata_reg, d_rdata_reg;

  // a requester holding req during its own gnt cycle is still finishing the
  // previous transfer and must not be granted again
  assign if_elig = if_req && !if_gnt;
  assign d_elig  = d_req && !d_gnt;

`ifdef ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt_reg;

  // count consecutive edges where fetch waits without being granted/issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (!if_req || if_gnt || if_win) begin
      starve_cnt_reg <= '0;
    end else if (starve_cnt_reg < CW'(STARVE_MAX)) begin
      starve_cnt_reg <= starve_cnt_reg + CW'(1);
    end
  end

  assign fetch_prio = (starve_cnt_reg >= CW'(STARVE_MAX));
`else
  assign fetch_prio = 1'b0;
`endif

  // arbitration and next-state: pick a winner among eligible requesters
  always_comb begin
    state_next = IDLE;
    owner_next = owner_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    if_win     = 1'b0;
    d_win      = 1'b0;
    if (if_elig && (fetch_prio || !d_elig)) begin
      if_win = 1'b1;
    end else if (d_elig) begin
      d_win = 1'b1;
    end
    if (if_win) begin
      state_next = ISSUE;
      owner_next = OWN_IF;
      we_next    = 1'b0;
      addr_next  = if_addr;
      wdata_next = '0;
    end else if (d_win) begin
      state_next = ISSUE;
      owner_next = OWN_D;
      we_next    = d_we;
      addr_next  = d_addr;
      wdata_next = d_wdata;
    end
  end

  // state register plus the latched winning request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IF;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // memory strobes and grants exist only while an access is being issued
  assign if_gnt    = (state_reg == ISSUE) && (owner_reg == OWN_IF);
  assign d_gnt     = (state_reg == ISSUE) && (owner_reg == OWN_D);
  assign mem_we    = d_gnt && we_reg;
  assign mem_re    = (state_reg == ISSUE) && !(owner_reg == OWN_D && we_reg);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  // return pipeline: one stage per cycle of memory latency; a read issued in
  // cycle N leaves the last stage in cycle N+MEM_LAT, aligned with mem_rdata
  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_ret
      if (gi == 0) begin : g_head
        // capture the read issued this cycle (stores leave a bubble)
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ret_valid_reg[gi] <= 1'b0;
            ret_owner_reg[gi] <= OWN_IF;
          end else begin
            ret_valid_reg[gi] <= mem_re;
            ret_owner_reg[gi] <= owner_reg;
          end
        end
      end else begin : g_stage
        // shift the in-flight read one stage closer to its return
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ret_valid_reg[gi] <= 1'b0;
            ret_owner_reg[gi] <= OWN_IF;
          end else begin
            ret_valid_reg[gi] <= ret_valid_reg[gi-1];
            ret_owner_reg[gi] <= ret_owner_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign ret_valid = ret_valid_reg[MEM_LAT-1];
  assign ret_owner = ret_owner_reg[MEM_LAT-1];
  assign if_rvalid = ret_valid && (ret_owner == OWN_IF);
  assign d_rvalid  = ret_valid && (ret_owner == OWN_D);

  // remember the last returned word per requester so non-owners see it held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      if (if_rvalid) if_rdata_reg <= mem_rdata;
      if (d_rvalid)  d_rdata_reg  <= mem_rdata;
    end
  end

  // returning data is forwarded in the same cycle it appears on mem_rdata
  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_reg;
  assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_reg;

endmodule
